// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer taking up to FETCH_WIDTH instructions per cycle
// and presenting one head instruction per cycle to decode. Optional same-cycle bypass via FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int ADDR        = 32,
  parameter int INST        = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush_,
  input  logic                            ic_e_,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0] ic_cnt,
  input  logic [ADDR-1:0]                 ic_pc,
  input  logic [FETCH_WIDTH*INST-1:0]     ic_inst,
  output logic                            fetch_stall_,
  input  logic                            dec_stall_,
  output logic                            inst_e_,
  output logic [ADDR-1:0]                 inst_pc,
  output logic [INST-1:0]                 inst,
  output logic [$clog2(DEPTH+1)-1:0]      count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(FETCH_WIDTH+1);

  typedef struct packed {
    logic [ADDR-1:0] pc;
    logic [INST-1:0] inst;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic            accept;
  logic            pop;
  logic            bypass;
  logic            head_vld;
  logic [IW-1:0]   wr_off;

  // Stall is based purely on registered occupancy so the fetch side never
  // sees a path through the decoder's stall.
  always_comb begin
    fetch_stall_ = !(count_q > CW'(DEPTH - FETCH_WIDTH));
    accept       = !ic_e_ && fetch_stall_ && flush_;
    head_vld     = (count_q != '0);
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass       = accept && !head_vld && dec_stall_;
`else
    bypass       = 1'b0;
`endif
    wr_off       = bypass ? IW'(1) : IW'(0);
    pop          = head_vld && flush_ && dec_stall_;
    inst_e_      = !((head_vld || bypass) && flush_);
  end

  // Head presentation; zeroed whenever nothing valid is shown.
  always_comb begin
    inst_pc = '0;
    inst    = '0;
    if (!inst_e_) begin
      if (bypass) begin
        inst_pc = ic_pc;
        inst    = ic_inst[0 +: INST];
      end else begin
        inst_pc = mem_q[head_q].pc;
        inst    = mem_q[head_q].inst;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < DEPTH; j++) mem_d[j] = mem_q[j];
    // Lane i lands at tail+i, shifted down by one when lane 0 was bypassed.
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (accept && (i >= int'(wr_off)) && (i < int'(ic_cnt))) begin
        mem_d[tail_q + PW'(i) - PW'(wr_off)].pc   = ic_pc + ADDR'(4 * i);
        mem_d[tail_q + PW'(i) - PW'(wr_off)].inst = ic_inst[i*INST +: INST];
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (!flush_) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        tail_d  = tail_q + PW'(ic_cnt) - PW'(wr_off);
        count_d = count_q + CW'(ic_cnt) - CW'(wr_off);
      end
      if (pop) begin
        head_d  = head_q + PW'(1);
        count_d = count_d - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count covers it.
  always_ff @(posedge clk) begin
    for (int j = 0; j < DEPTH; j++) mem_q[j] <= mem_d[j];
  end

  assign count = count_q;

  a_count_range: assert property (@(posedge clk) disable iff (reset)
    count_q <= CW'(DEPTH));
  a_cnt_legal: assert property (@(posedge clk) disable iff (reset)
    accept |-> ((ic_cnt != '0) && (ic_cnt <= IW'(FETCH_WIDTH))));

endmodule
